mem_stage_access_unit: RTL and testbench

- Consumer of the execute/memory pipeline-register outputs. Turns em_* load/store controls into data-memory bus transactions using a req/gnt/rvalid handshake.
- Stalls the pipeline while a transaction is in flight.
- Aligns and extends load data, selects the writeback value, and registers the result into the memory/writeback stage outputs.

---
 rtl/mem_stage_access_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_stage_access_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_unit.sv
// Memory-stage access unit: issues data-memory req/gnt/rvalid transactions for
// loads and stores, stalls while one is in flight, and registers the writeback slot.
module mem_stage_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              em_valid_i,
    input  logic              em_reg_write_i,
    input  logic              em_mem_read_i,
    input  logic              em_mem_write_i,
    input  logic [2:0]        em_funct3_i,
    input  logic [1:0]        em_dmem_to_reg_i,
    input  logic [4:0]        em_write_addr_reg_i,
    input  logic [31:0]       em_alu_result_i,
    input  logic [31:0]       em_read_data2_i,
    input  logic [31:0]       em_pc_new_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              mw_valid_o,
    output logic              mw_reg_write_o,
    output logic [4:0]        mw_write_addr_reg_o,
    output logic [31:0]       mw_wb_data_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_q;
    logic              rw_q;
    logic [1:0]        sel_q;
    logic [31:0]       alu_q;
    logic [31:0]       pc_q;

    logic              access, is_store, misal;
    logic [1:0]        off, size;
    logic [ADDR_W-1:0] addr_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic              retire, mis_evt, capture;

    logic              idle;
    logic [2:0]        src_f3;
    logic [1:0]        src_off, src_sel;
    logic [4:0]        src_rd;
    logic              src_rw, src_we;
    logic [31:0]       src_alu, src_pc;
    logic              valid_d, rw_d;
    logic [31:0]       wb_d;

    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0] sh_off,
                                                 input logic [2:0] f3);
        logic [31:0] sh;
        sh = rdata >> {sh_off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h000000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign access   = em_valid_i & (em_mem_read_i | em_mem_write_i);
    assign is_store = em_mem_write_i;
    assign off      = em_alu_result_i[1:0];
    assign size     = em_funct3_i[1:0];
    assign misal    = ((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00));
    assign addr_c   = {em_alu_result_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = em_read_data2_i;
        case (size)
            2'b00: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{em_read_data2_i[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << off;
                wdata_c = {2{em_read_data2_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Stall drops in the retiring cycle so the pipeline advances past the
    // completed access instead of re-presenting it to IDLE.
    always_comb begin
        state_d      = state_q;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        stall_o      = 1'b0;
        retire       = 1'b0;
        mis_evt      = 1'b0;
        capture      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && misal) begin
                    mis_evt = 1'b1;
                end else if (access) begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = is_store;
                    dmem_addr_o  = addr_c;
                    dmem_be_o    = be_c;
                    dmem_wdata_o = wdata_c;
                    capture      = 1'b1;
                    if (dmem_gnt_i && (is_store || dmem_rvalid_i)) begin
                        retire = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        state_d = dmem_gnt_i ? RESP : REQ;
                    end
                end
            end
            REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_addr_o  = addr_q;
                dmem_be_o    = be_q;
                dmem_wdata_o = wdata_q;
                if (dmem_gnt_i && (we_q || dmem_rvalid_i)) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (dmem_gnt_i) state_d = RESP;
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset_i) begin
            state_d      = IDLE;
            dmem_req_o   = 1'b0;
            dmem_we_o    = 1'b0;
            dmem_addr_o  = '0;
            dmem_be_o    = '0;
            dmem_wdata_o = '0;
            stall_o      = 1'b0;
            retire       = 1'b0;
            mis_evt      = 1'b0;
            capture      = 1'b0;
        end
    end

    assign idle    = (state_q == IDLE);
    assign src_f3  = idle ? em_funct3_i         : f3_q;
    assign src_off = idle ? off                 : off_q;
    assign src_sel = idle ? em_dmem_to_reg_i    : sel_q;
    assign src_rd  = idle ? em_write_addr_reg_i : rd_q;
    assign src_rw  = idle ? em_reg_write_i      : rw_q;
    assign src_we  = idle ? is_store            : we_q;
    assign src_alu = idle ? em_alu_result_i     : alu_q;
    assign src_pc  = idle ? em_pc_new_i         : pc_q;

    always_comb begin
        valid_d = idle ? (em_valid_i & (~access | mis_evt | retire)) : retire;
        rw_d    = valid_d & src_rw & (src_rd != 5'd0) & ~mis_evt;
        if (retire && !src_we && src_sel == 2'b01) begin
            wb_d = load_extract(dmem_rdata_i, src_off, src_f3);
        end else if (src_sel == 2'b10) begin
            wb_d = src_pc;
        end else begin
            wb_d = src_alu;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q             <= IDLE;
            misalign_o          <= 1'b0;
            mw_valid_o          <= 1'b0;
            mw_reg_write_o      <= 1'b0;
            mw_write_addr_reg_o <= '0;
            mw_wb_data_o        <= '0;
            we_q                <= 1'b0;
            addr_q              <= '0;
            be_q                <= '0;
            wdata_q             <= '0;
            f3_q                <= '0;
            off_q               <= '0;
            rd_q                <= '0;
            rw_q                <= 1'b0;
            sel_q               <= '0;
            alu_q               <= '0;
            pc_q                <= '0;
        end else begin
            state_q             <= state_d;
            misalign_o          <= mis_evt;
            mw_valid_o          <= valid_d;
            mw_reg_write_o      <= rw_d;
            mw_write_addr_reg_o <= src_rd;
            mw_wb_data_o        <= wb_d;
            if (capture) begin
                we_q    <= is_store;
                addr_q  <= addr_c;
                be_q    <= be_c;
                wdata_q <= wdata_c;
                f3_q    <= em_funct3_i;
                off_q   <= off;
                rd_q    <= em_write_addr_reg_i;
                rw_q    <= em_reg_write_i;
                sel_q   <= em_dmem_to_reg_i;
                alu_q   <= em_alu_result_i;
                pc_q    <= em_pc_new_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed vector table, multi-cycle sequences
// and randomized transactions checked against a lane/extension reference model.
module tb_mem_stage_access_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              em_valid_i, em_reg_write_i, em_mem_read_i, em_mem_write_i;
    logic [2:0]        em_funct3_i;
    logic [1:0]        em_dmem_to_reg_i;
    logic [4:0]        em_write_addr_reg_i;
    logic [31:0]       em_alu_result_i, em_read_data2_i, em_pc_new_i;
    logic              dmem_req_o, dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [3:0]        dmem_be_o;
    logic [31:0]       dmem_wdata_o;
    logic              dmem_gnt_i, dmem_rvalid_i;
    logic [31:0]       dmem_rdata_i;
    logic              stall_o, misalign_o, mw_valid_o, mw_reg_write_o;
    logic [4:0]        mw_write_addr_reg_o;
    logic [31:0]       mw_wb_data_o;

    always #5 clk = ~clk;

    mem_stage_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .em_valid_i(em_valid_i), .em_reg_write_i(em_reg_write_i),
        .em_mem_read_i(em_mem_read_i), .em_mem_write_i(em_mem_write_i),
        .em_funct3_i(em_funct3_i), .em_dmem_to_reg_i(em_dmem_to_reg_i),
        .em_write_addr_reg_i(em_write_addr_reg_i), .em_alu_result_i(em_alu_result_i),
        .em_read_data2_i(em_read_data2_i), .em_pc_new_i(em_pc_new_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .misalign_o(misalign_o), .mw_valid_o(mw_valid_o),
        .mw_reg_write_o(mw_reg_write_o), .mw_write_addr_reg_o(mw_write_addr_reg_o),
        .mw_wb_data_o(mw_wb_data_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: sizes 0 byte, 1 half, 2/3 word taken from funct3 low bits.
    function automatic logic m_misal(input int unsigned sz, input int unsigned o);
        if (sz == 1) return (o % 2) != 0;
        if (sz >= 2) return o != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_be(input int unsigned sz, input int unsigned o);
        if (sz == 0) return 32'(1 << o);
        if (sz == 1) return 32'(3 << o);
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int unsigned sz, input logic [31:0] d);
        if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int unsigned f3, input int unsigned o,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] part;
        v = rdata >> (8 * o);
        case (f3)
            0: begin part = v & 32'hFF;   return (part >= 128)   ? part + 32'hFFFF_FF00 : part; end
            1: begin part = v & 32'hFFFF; return (part >= 32768) ? part + 32'hFFFF_0000 : part; end
            4: return v & 32'hFF;
            5: return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    task automatic drive(input logic v, input logic rw, input logic rdm, input logic wr,
                         input logic [2:0] f3, input logic [1:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc);
        em_valid_i = v; em_reg_write_i = rw; em_mem_read_i = rdm; em_mem_write_i = wr;
        em_funct3_i = f3; em_dmem_to_reg_i = sel; em_write_addr_reg_i = rd;
        em_alu_result_i = alu; em_read_data2_i = rs2; em_pc_new_i = pc;
    endtask

    typedef struct {
        string       name;
        logic        v, rw, rdm, wr;
        logic [2:0]  f3;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] alu, rs2, pc, rdata;
        logic        gnt, rv;
        logic        x_req;
        logic [3:0]  x_be;
        logic [31:0] x_addr, x_wdata;
        logic        x_stall, x_valid, x_rw, x_mis;
        logic [31:0] x_wb;
    } vec_t;

    function automatic vec_t mkv(input string nm, input logic v, input logic rw, input logic rdm,
                                 input logic wr, input logic [2:0] f3, input logic [1:0] sel,
                                 input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic [31:0] pc,
                                 input logic [31:0] rdata, input logic gnt, input logic rv,
                                 input logic x_req, input logic [3:0] x_be,
                                 input logic [31:0] x_addr, input logic [31:0] x_wdata,
                                 input logic x_stall, input logic x_valid, input logic x_rw,
                                 input logic x_mis, input logic [31:0] x_wb);
        vec_t e;
        e.name = nm; e.v = v; e.rw = rw; e.rdm = rdm; e.wr = wr; e.f3 = f3; e.sel = sel;
        e.rd = rd; e.alu = alu; e.rs2 = rs2; e.pc = pc; e.rdata = rdata; e.gnt = gnt;
        e.rv = rv; e.x_req = x_req; e.x_be = x_be; e.x_addr = x_addr; e.x_wdata = x_wdata;
        e.x_stall = x_stall; e.x_valid = x_valid; e.x_rw = x_rw; e.x_mis = x_mis;
        e.x_wb = x_wb;
        return e;
    endfunction

    vec_t        tbl[16];
    int          stall_cnt;
    int unsigned kind, sz, o, gd, rvd, ret;
    logic        v, rw, rdm, wr, stray, acc, mis, mal, st, x_rw;
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu, rs2, pc, rdata, x_wb;

    initial begin
        tbl[0]  = mkv("alu",     1,1,0,0, 3'd0,2'd0, 5'd5,  32'h1234, 0, 0, 0, 0,0,
                      0,4'b0000,0,0, 0, 1,1,0, 32'h1234);
        tbl[1]  = mkv("sb",      1,0,0,1, 3'd0,2'd0, 5'd0,  32'h103, 32'hAABBCCDD, 0, 0, 1,0,
                      1,4'b1000,32'h100,32'hDDDDDDDD, 0, 1,0,0, 0);
        tbl[2]  = mkv("lbu",     1,1,1,0, 3'd4,2'd1, 5'd7,  32'h1, 0, 0, 32'h0000F000, 1,1,
                      1,4'b0010,0,0, 0, 1,1,0, 32'h000000F0);
        tbl[3]  = mkv("lb",      1,1,1,0, 3'd0,2'd1, 5'd7,  32'h1, 0, 0, 32'h0000F000, 1,1,
                      1,4'b0010,0,0, 0, 1,1,0, 32'hFFFFFFF0);
        tbl[4]  = mkv("lw_mis",  1,1,1,0, 3'd2,2'd1, 5'd9,  32'h6, 0, 0, 0, 0,0,
                      0,4'b0000,0,0, 0, 1,0,1, 0);
        tbl[5]  = mkv("jal_r0",  1,1,0,0, 3'd0,2'd2, 5'd0,  32'h999, 0, 32'h44, 0, 0,0,
                      0,4'b0000,0,0, 0, 1,0,0, 0);
        tbl[6]  = mkv("jal_r1",  1,1,0,0, 3'd0,2'd2, 5'd1,  32'h999, 0, 32'h44, 0, 0,0,
                      0,4'b0000,0,0, 0, 1,1,0, 32'h44);
        tbl[7]  = mkv("bubble",  0,1,1,0, 3'd2,2'd1, 5'd3,  32'h8, 0, 0, 32'h55, 0,1,
                      0,4'b0000,0,0, 0, 0,0,0, 0);
        tbl[8]  = mkv("sh_hi",   1,0,0,1, 3'd1,2'd0, 5'd0,  32'h2, 32'h1234ABCD, 0, 0, 1,0,
                      1,4'b1100,32'h0,32'hABCDABCD, 0, 1,0,0, 0);
        tbl[9]  = mkv("sw",      1,0,0,1, 3'd2,2'd0, 5'd0,  32'h40, 32'hCAFEF00D, 0, 0, 1,0,
                      1,4'b1111,32'h40,32'hCAFEF00D, 0, 1,0,0, 0);
        tbl[10] = mkv("lhu",     1,1,1,0, 3'd5,2'd1, 5'd10, 32'h202, 0, 0, 32'h80010000, 1,1,
                      1,4'b1100,32'h200,0, 0, 1,1,0, 32'h00008001);
        tbl[11] = mkv("sh_mis",  1,0,0,1, 3'd1,2'd0, 5'd0,  32'h1, 32'h55, 0, 0, 1,0,
                      0,4'b0000,0,0, 0, 1,0,1, 0);
        tbl[12] = mkv("rd_wr",   1,0,1,1, 3'd0,2'd1, 5'd8,  32'h5, 32'h77, 0, 32'h12345678, 1,1,
                      1,4'b0010,32'h4,32'h77777777, 0, 1,0,0, 0);
        tbl[13] = mkv("stray",   1,1,0,0, 3'd0,2'd3, 5'd4,  32'h55, 0, 32'h66, 32'hFFFFFFFF, 0,1,
                      0,4'b0000,0,0, 0, 1,1,0, 32'h55);
        tbl[14] = mkv("lw_sel0", 1,1,1,0, 3'd2,2'd0, 5'd6,  32'h10, 0, 0, 32'hDEAD, 1,1,
                      1,4'b1111,32'h10,0, 0, 1,1,0, 32'h10);
        tbl[15] = mkv("lh_sx",   1,1,1,0, 3'd1,2'd1, 5'd12, 32'h0, 0, 0, 32'h00018000, 1,1,
                      1,4'b0011,32'h0,0, 0, 1,1,0, 32'hFFFF8000);

        reset_i = 1'b1;
        drive(0,0,0,0, 3'd0, 2'd0, 5'd0, 0, 0, 0);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst.req", dmem_req_o, 1'b0);
        chk1("rst.stall", stall_o, 1'b0);
        chk1("rst.mw_valid", mw_valid_o, 1'b0);
        chk1("rst.mw_rw", mw_reg_write_o, 1'b0);
        chk1("rst.misalign", misalign_o, 1'b0);
        chk32("rst.mw_wb", mw_wb_data_o, 32'h0);
        reset_i = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rw, tbl[i].rdm, tbl[i].wr, tbl[i].f3, tbl[i].sel,
                  tbl[i].rd, tbl[i].alu, tbl[i].rs2, tbl[i].pc);
            dmem_gnt_i = tbl[i].gnt; dmem_rvalid_i = tbl[i].rv; dmem_rdata_i = tbl[i].rdata;
            #1;
            chk1({tbl[i].name, ".req"}, dmem_req_o, tbl[i].x_req);
            if (tbl[i].x_req) begin
                chk1({tbl[i].name, ".we"}, dmem_we_o, tbl[i].wr);
                chk32({tbl[i].name, ".addr"}, dmem_addr_o, tbl[i].x_addr);
                chk32({tbl[i].name, ".be"}, 32'(dmem_be_o), 32'(tbl[i].x_be));
                if (tbl[i].wr) chk32({tbl[i].name, ".wdata"}, dmem_wdata_o, tbl[i].x_wdata);
            end
            chk1({tbl[i].name, ".stall"}, stall_o, tbl[i].x_stall);
            @(posedge clk); #1;
            chk1({tbl[i].name, ".mw_valid"}, mw_valid_o, tbl[i].x_valid);
            chk1({tbl[i].name, ".mw_rw"}, mw_reg_write_o, tbl[i].x_rw);
            chk1({tbl[i].name, ".misalign"}, misalign_o, tbl[i].x_mis);
            if (tbl[i].x_rw) chk32({tbl[i].name, ".mw_wb"}, mw_wb_data_o, tbl[i].x_wb);
        end

        // LH at 0x2: gnt in cycle 2, rvalid in cycle 6.
        drive(1,1,1,0, 3'd1, 2'd1, 5'd11, 32'h2, 0, 0);
        stall_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            dmem_gnt_i    = (c == 2);
            dmem_rvalid_i = (c == 6);
            dmem_rdata_i  = (c == 6) ? 32'h80010000 : 32'h0;
            #1;
            if (stall_o) stall_cnt++;
            chk1("lh_seq.req", dmem_req_o, c <= 2);
            if (c <= 2) begin
                chk32("lh_seq.addr", dmem_addr_o, 32'h0);
                chk32("lh_seq.be", 32'(dmem_be_o), 32'hC);
            end
            chk1("lh_seq.stall", stall_o, c < 6);
            @(posedge clk); #1;
            chk1("lh_seq.mw_valid", mw_valid_o, c == 6);
        end
        chk32("lh_seq.stall_cycles", 32'(stall_cnt), 32'd6);
        chk1("lh_seq.mw_rw", mw_reg_write_o, 1'b1);
        chk32("lh_seq.mw_rd", 32'(mw_write_addr_reg_o), 32'd11);
        chk32("lh_seq.mw_wb", mw_wb_data_o, 32'hFFFF8001);

        // LW granted at once, then reset while waiting for rvalid.
        drive(1,1,1,0, 3'd2, 2'd1, 5'd13, 32'h20, 0, 0);
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
        #1;
        chk1("rst_resp.stall_pre", stall_o, 1'b1);
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        reset_i = 1'b1;
        #1;
        chk1("rst_resp.req", dmem_req_o, 1'b0);
        chk1("rst_resp.stall", stall_o, 1'b0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk1("rst_resp.mw_valid", mw_valid_o, 1'b0);
        chk1("rst_resp.mw_rw", mw_reg_write_o, 1'b0);
        chk32("rst_resp.mw_wb", mw_wb_data_o, 32'h0);
        drive(0,1,1,0, 3'd2, 2'd1, 5'd13, 32'h20, 0, 0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234;
        #1;
        chk1("rst_resp.idle_stall", stall_o, 1'b0);
        chk1("rst_resp.idle_req", dmem_req_o, 1'b0);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        chk1("rst_resp.late_rvalid_valid", mw_valid_o, 1'b0);
        chk1("rst_resp.late_rvalid_rw", mw_reg_write_o, 1'b0);

        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 3);
            v    = (kind != 3);
            rdm  = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
            wr   = (kind == 2);
            f3   = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            sel  = 2'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 31));
            rw   = ($urandom_range(0, 3) != 0);
            alu  = $urandom; rs2 = $urandom; pc = $urandom; rdata = $urandom;
            sz   = f3 & 3;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 1) alu = alu & ~32'h1;
                else if (sz >= 2) alu = alu & ~32'h3;
            end
            o     = alu & 3;
            acc   = v && (rdm || wr);
            st    = wr;
            mis   = acc && m_misal(sz, o);
            mal   = acc && !mis;
            gd    = $urandom_range(0, 2);
            rvd   = $urandom_range(0, 2);
            ret   = mal ? (st ? gd : gd + rvd) : 0;
            stray = !mal && ($urandom_range(0, 1) == 1);
            x_rw  = v && rw && (rd != 0) && !mis;
            if (mal && !st && sel == 1) x_wb = m_load(f3, o, rdata);
            else if (sel == 2)          x_wb = pc;
            else                        x_wb = alu;
            drive(v, rw, rdm, wr, f3, sel, rd, alu, rs2, pc);
            for (int unsigned c = 0; c <= ret; c++) begin
                dmem_gnt_i    = mal && (c == gd);
                dmem_rvalid_i = (mal && !st && c == gd + rvd) || stray;
                dmem_rdata_i  = rdata;
                #1;
                chk1("rnd.req", dmem_req_o, mal && c <= gd);
                if (mal && c <= gd) begin
                    chk32("rnd.addr", dmem_addr_o, alu & ~32'h3);
                    chk1("rnd.we", dmem_we_o, st);
                    chk32("rnd.be", 32'(dmem_be_o), m_be(sz, o));
                    if (st) chk32("rnd.wdata", dmem_wdata_o, m_wdata(sz, rs2));
                end
                chk1("rnd.stall", stall_o, mal && c != ret);
                @(posedge clk); #1;
                chk1("rnd.mw_valid", mw_valid_o, (c == ret) && v);
                chk1("rnd.misalign", misalign_o, (c == ret) && mis);
                if (c == ret) begin
                    chk1("rnd.mw_rw", mw_reg_write_o, x_rw);
                    if (v) chk32("rnd.mw_rd", 32'(mw_write_addr_reg_o), 32'(rd));
                    if (x_rw) chk32("rnd.mw_wb", mw_wb_data_o, x_wb);
                end
            end
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
